// File: rtl/states_pkg.sv
// rtl/states_pkg.sv - shared core and load/store phase encodings
package states_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_t;

    // The scheduler decodes this same type to know when all lanes finished.
    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    localparam int WD_COUNT_BITS = 16;

endpackage

// File: rtl/thread_lsu_if.sv
// rtl/thread_lsu_if.sv - data-memory read/write handshake bundle for one lane
interface thread_lsu_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_watchdog.sv
// rtl/lsu_watchdog.sv - WAITING-cycle counter with expire pulse, built only with LSU_TIMEOUT_EN
`ifdef LSU_TIMEOUT_EN
module lsu_watchdog
    import states_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic i_active,
    output logic o_expire
);
    localparam logic [WD_COUNT_BITS-1:0] LIMIT_M1 = WD_COUNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [WD_COUNT_BITS-1:0] r_count;

    // Fires on the edge that would complete the TIMEOUT_CYCLES-th waiting cycle.
    assign o_expire = i_active && (r_count == LIMIT_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (enable) begin
            if (!i_active || o_expire) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/thread_lsu.sv
// rtl/thread_lsu.sv - per-lane load/store unit; optional watchdog under LSU_TIMEOUT_EN
module thread_lsu
    import states_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  core_state_t          core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [7:0]           rt,
    thread_lsu_if.master         mem,
    output lsu_state_t           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("thread_lsu: TIMEOUT_CYCLES out of range");
    end

    lsu_state_t           r_state;
    logic                 r_is_read;
    logic                 r_read_valid;
    logic                 r_write_valid;
    logic [ADDR_BITS-1:0] r_read_addr;
    logic [ADDR_BITS-1:0] r_write_addr;
    logic [DATA_BITS-1:0] r_write_data;
    logic [DATA_BITS-1:0] r_lsu_out;

    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_wdata;
    logic                 w_read_done;
    logic                 w_write_done;
    logic                 w_expire;

    assign w_addr  = ADDR_BITS'(rs);
    assign w_wdata = DATA_BITS'(rt);

    // Valids are only ever high in WAITING, so gating by valid also gates by state.
    assign w_read_done  = r_read_valid  && mem.mem_read_ready;
    assign w_write_done = r_write_valid && mem.mem_write_ready;

`ifdef LSU_TIMEOUT_EN
    logic r_error;

    lsu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .i_active (r_state == LSU_WAITING),
        .o_expire (w_expire)
    );

    assign lsu_error = r_error;
`else
    assign w_expire  = 1'b0;
    assign lsu_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= LSU_IDLE;
            r_is_read     <= 1'b0;
            r_read_valid  <= 1'b0;
            r_write_valid <= 1'b0;
            r_read_addr   <= '0;
            r_write_addr  <= '0;
            r_write_data  <= '0;
            r_lsu_out     <= '0;
`ifdef LSU_TIMEOUT_EN
            r_error       <= 1'b0;
`endif
        end else if (enable) begin
            case (r_state)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        r_is_read <= decoded_mem_read_enable;
                        r_state   <= LSU_REQUESTING;
                    end
                end
                LSU_REQUESTING: begin
                    if (r_is_read) begin
                        r_read_valid <= 1'b1;
                        r_read_addr  <= w_addr;
                    end else begin
                        r_write_valid <= 1'b1;
                        r_write_addr  <= w_addr;
                        r_write_data  <= w_wdata;
                    end
                    r_state <= LSU_WAITING;
                end
                LSU_WAITING: begin
                    // A handshake on the expiry edge takes priority over the timeout.
                    if (w_read_done) begin
                        r_lsu_out    <= mem.mem_read_data;
                        r_read_valid <= 1'b0;
                        r_state      <= LSU_DONE;
                    end else if (w_write_done) begin
                        r_write_valid <= 1'b0;
                        r_state       <= LSU_DONE;
                    end else if (w_expire) begin
                        r_read_valid  <= 1'b0;
                        r_write_valid <= 1'b0;
                        if (r_is_read) begin
                            r_lsu_out <= '0;
                        end
`ifdef LSU_TIMEOUT_EN
                        r_error       <= 1'b1;
`endif
                        r_state       <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
`ifdef LSU_TIMEOUT_EN
                        r_error <= 1'b0;
`endif
                        r_state <= LSU_IDLE;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign mem.mem_read_valid    = r_read_valid;
    assign mem.mem_read_address  = r_read_addr;
    assign mem.mem_write_valid   = r_write_valid;
    assign mem.mem_write_address = r_write_addr;
    assign mem.mem_write_data    = r_write_data;
    assign lsu_state             = r_state;
    assign lsu_out               = r_lsu_out;
endmodule

// File: tb/tb_thread_lsu.sv
// tb/tb_thread_lsu.sv - vector-table and sequence checks for thread_lsu
module tb_thread_lsu;
    import states_pkg::*;

    localparam int T = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    core_state_t core_state = CORE_IDLE;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  rs = '0;
    logic [7:0]  rt = '0;
    lsu_state_t  lsu_state;
    logic [7:0]  lsu_out;
    logic        lsu_error;

    int total = 0;
    int bad   = 0;

    thread_lsu_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem_bus ();

    thread_lsu #(
        .DATA_BITS      (8),
        .ADDR_BITS      (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem                      (mem_bus),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] rs;
        logic [7:0] rt;
        int         waits;
        logic [7:0] rdata;
        bit         exp_read;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_out;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rcnt;
        int wcnt;
        bit to;
        logic [7:0] eo;
        int ev;
        to = TMO_EN && (v.waits >= T);
        eo = (to && v.exp_read) ? 8'h00 : v.exp_out;
        ev = to ? T : v.waits + 1;

        core_state = CORE_REQUEST;
        rd_en = v.rd; wr_en = v.wr; rs = v.rs; rt = v.rt;
        step();
        chk($sformatf("v%0d_requesting", idx), lsu_state, LSU_REQUESTING);
        core_state = CORE_WAIT;
        step();
        chk($sformatf("v%0d_waiting", idx), lsu_state, LSU_WAITING);
        if (v.exp_read) begin
            chk($sformatf("v%0d_raddr", idx), mem_bus.mem_read_address, v.exp_addr);
            mem_bus.mem_write_ready = 1'b1;
        end else begin
            chk($sformatf("v%0d_waddr", idx), mem_bus.mem_write_address, v.exp_addr);
            chk($sformatf("v%0d_wdata", idx), mem_bus.mem_write_data, v.exp_wdata);
            mem_bus.mem_read_ready = 1'b1;
            mem_bus.mem_read_data  = 8'hEE;
        end
        rcnt = 0;
        wcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (lsu_state != LSU_WAITING) break;
            rcnt += int'(mem_bus.mem_read_valid);
            wcnt += int'(mem_bus.mem_write_valid);
            if (c == v.waits) begin
                if (v.exp_read) begin
                    mem_bus.mem_read_ready = 1'b1;
                    mem_bus.mem_read_data  = v.rdata;
                end else begin
                    mem_bus.mem_write_ready = 1'b1;
                end
            end
            step();
            mem_bus.mem_read_ready  = 1'b0;
            mem_bus.mem_write_ready = 1'b0;
            mem_bus.mem_read_data   = 8'h00;
            if (v.exp_read) mem_bus.mem_write_ready = 1'b1;
            else            mem_bus.mem_read_ready  = 1'b1;
        end
        mem_bus.mem_read_ready  = 1'b0;
        mem_bus.mem_write_ready = 1'b0;
        chk($sformatf("v%0d_rvalid_cycles", idx), rcnt, v.exp_read ? ev : 0);
        chk($sformatf("v%0d_wvalid_cycles", idx), wcnt, v.exp_read ? 0 : ev);
        chk($sformatf("v%0d_done", idx), lsu_state, LSU_DONE);
        chk($sformatf("v%0d_valids_low", idx),
            {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
        chk($sformatf("v%0d_out", idx), lsu_out, eo);
        chk($sformatf("v%0d_error", idx), lsu_error, to);
        if (v.exp_read)
            chk($sformatf("v%0d_raddr_held", idx), mem_bus.mem_read_address, v.exp_addr);
        else
            chk($sformatf("v%0d_waddr_held", idx), mem_bus.mem_write_address, v.exp_addr);

        core_state = CORE_EXECUTE;
        step();
        chk($sformatf("v%0d_done_hold", idx), lsu_state, LSU_DONE);
        core_state = CORE_UPDATE;
        step();
        chk($sformatf("v%0d_idle", idx), lsu_state, LSU_IDLE);
        chk($sformatf("v%0d_out_after_update", idx), lsu_out, eo);
        chk($sformatf("v%0d_error_cleared", idx), lsu_error, 1'b0);
        core_state = CORE_FETCH;
        rd_en = 1'b0; wr_en = 1'b0;
        step();
    endtask

    vec_t vecs[6];

    initial begin
        int vcnt;
        vecs[0] = '{1, 0, 8'h12, 8'h00, 0, 8'hA5, 1, 8'h12, 8'h00, 8'hA5};
        vecs[1] = '{0, 1, 8'h30, 8'h7E, 4, 8'h00, 0, 8'h30, 8'h7E, 8'hA5};
        vecs[2] = '{1, 1, 8'h05, 8'h33, 1, 8'h5C, 1, 8'h05, 8'h00, 8'h5C};
        vecs[3] = '{1, 0, 8'hFF, 8'h00, 3, 8'hC3, 1, 8'hFF, 8'h00, 8'hC3};
        vecs[4] = '{0, 1, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hC3};
        vecs[5] = '{1, 0, 8'h44, 8'h00, 2, 8'h3C, 1, 8'h44, 8'h00, 8'h3C};

        mem_bus.mem_read_ready  = 1'b0;
        mem_bus.mem_read_data   = 8'h00;
        mem_bus.mem_write_ready = 1'b0;

        #12;
        chk("reset_state", lsu_state, LSU_IDLE);
        chk("reset_valids", {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
        chk("reset_addrs", {mem_bus.mem_read_address, mem_bus.mem_write_address}, 16'h0000);
        chk("reset_wdata", mem_bus.mem_write_data, 8'h00);
        chk("reset_out", lsu_out, 8'h00);
        chk("reset_error", lsu_error, 1'b0);
        reset = 1'b1;
        step();

        core_state = CORE_REQUEST;
        step();
        step();
        chk("no_enable_idle", lsu_state, LSU_IDLE);
        chk("no_enable_valids", {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
        core_state = CORE_FETCH;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset asserted mid-handshake.
        core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h77;
        step();
        core_state = CORE_WAIT;
        step();
        chk("rst_pre_valid", mem_bus.mem_read_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst_valids", {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
        chk("rst_state", lsu_state, LSU_IDLE);
        chk("rst_out", lsu_out, 8'h00);
        core_state = CORE_FETCH; rd_en = 1'b0;
        step();
        #2 reset = 1'b1;
        step();
        chk("rst_release_idle", lsu_state, LSU_IDLE);

        // Freeze while WAITING; ready pulses must be ignored.
        core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h21;
        step();
        core_state = CORE_WAIT;
        step();
        enable = 1'b0;
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz%0d_state", i), lsu_state, LSU_WAITING);
            chk($sformatf("frz%0d_valid", i), mem_bus.mem_read_valid, 1'b1);
            chk($sformatf("frz%0d_addr", i), mem_bus.mem_read_address, 8'h21);
            chk($sformatf("frz%0d_out", i), lsu_out, 8'h00);
        end
        enable = 1'b1;
        mem_bus.mem_read_ready = 1'b0;
        step();
        chk("frz_resume_wait", lsu_state, LSU_WAITING);
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 8'h6B;
        step();
        mem_bus.mem_read_ready = 1'b0;
        chk("frz_done", lsu_state, LSU_DONE);
        chk("frz_out", lsu_out, 8'h6B);
        chk("frz_valid_low", mem_bus.mem_read_valid, 1'b0);
        core_state = CORE_UPDATE;
        step();
        chk("frz_idle", lsu_state, LSU_IDLE);
        core_state = CORE_FETCH; rd_en = 1'b0;
        step();

`ifdef LSU_TIMEOUT_EN
        core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h10;
        step();
        core_state = CORE_WAIT;
        step();
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (lsu_state != LSU_WAITING) break;
            vcnt += int'(mem_bus.mem_read_valid);
            step();
        end
        chk("tmo_valid_cycles", vcnt, T);
        chk("tmo_done", lsu_state, LSU_DONE);
        chk("tmo_valid_low", mem_bus.mem_read_valid, 1'b0);
        chk("tmo_error", lsu_error, 1'b1);
        chk("tmo_out", lsu_out, 8'h00);
        core_state = CORE_UPDATE;
        step();
        chk("tmo_idle", lsu_state, LSU_IDLE);
        chk("tmo_error_clear", lsu_error, 1'b0);
        core_state = CORE_FETCH; rd_en = 1'b0;
        step();
`else
        vcnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/thread_lsu.md
# thread_lsu

Per-thread load/store unit, one instance per thread lane beside that lane's register file. It consumes the `rs`/`rt` operands the register file latches in REQUEST and issues one data-memory read or write per instruction through a valid/ready handshake. It returns load data on `lsu_out`, which the register file writes back in UPDATE when the reg-input mux selects MEMORY. `lsu_state` tells the core scheduler when every lane's memory access has completed.

## Interface
- `DATA_BITS`, 8: width of load/store data and of `lsu_out`.
- `ADDR_BITS`, 8: width of data-memory addresses; the address is taken from `rs`.
- `TIMEOUT_CYCLES`, 255: watchdog limit, used only when `LSU_TIMEOUT_EN` is defined; legal range 1..65535.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; low clears all state immediately.
- `enable` input 1: lane active in the current block; when low the unit is frozen.
- `core_state` input 3: core phase, `core_state_t` from `states_pkg`.
- `decoded_mem_read_enable` input 1: the current instruction is LDR.
- `decoded_mem_write_enable` input 1: the current instruction is STR.
- `rs` input 8: address operand; bits [ADDR_BITS-1:0] are used, upper bits are zero-extended or dropped as the width requires.
- `rt` input 8: store-data operand, truncated or zero-extended to DATA_BITS.
- `mem_read_valid` output 1: read request.
- `mem_read_address` output ADDR_BITS: read address.
- `mem_read_ready` input 1: read accepted; `mem_read_data` is valid in the same cycle.
- `mem_read_data` input DATA_BITS: read data.
- `mem_write_valid` output 1: write request.
- `mem_write_address` output ADDR_BITS: write address.
- `mem_write_data` output DATA_BITS: write data.
- `mem_write_ready` input 1: write accepted.
- `lsu_state` output 2: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- `lsu_out` output DATA_BITS: last load result.
- `lsu_error` output 1: the last access timed out.

## Operation
- Reset value of every output is 0: both valids, both addresses, `mem_write_data`, `lsu_out`, `lsu_error` and `lsu_state` (IDLE). Any watchdog count is also cleared.
- When `enable` is low:
  - state, counter and all outputs hold;
  - handshake inputs are ignored.
- IDLE → REQUESTING on an edge where `core_state`==REQUEST and either memory enable is high. With neither enable high, the unit stays in IDLE.
- REQUESTING → WAITING on the next edge:
  - read: `mem_read_valid`=1 and `mem_read_address`=`rs`;
  - write: `mem_write_valid`=1, `mem_write_address`=`rs`, `mem_write_data`=`rt`.
- If both enables are high, the read wins and the write is ignored.
- WAITING → DONE on the first edge where the matching ready is high:
  - read: `lsu_out` captures `mem_read_data`;
  - either way, the request valid is deasserted on that edge.
- Address and data outputs hold their last values after the valid drops.
- A ready input is ignored unless the matching valid is high and the state is WAITING.
- DONE → IDLE on an edge where `core_state`==UPDATE. `lsu_out` holds through UPDATE so the register file can write it back.
- A `reset` assertion in any state, including mid-handshake, drops both valids immediately. No completion is reported for the aborted access.

## Timing
- Minimum latency with zero-wait memory, counting edges from the one that samples `core_state`==REQUEST:
  - edge 1: REQUESTING;
  - edge 2: valid high;
  - edge 3: DONE, with `lsu_out` updated on the same edge as the read handshake.
- Each additional cycle that ready stays low adds one cycle in WAITING.
- Every valid stays high until the edge on which the matching ready is sampled high; a valid is never withdrawn early except by reset or timeout.
- There is at most one outstanding access per lane.
- Outputs are registered and have no combinational path from any input.

## Configuration
- With `LSU_TIMEOUT_EN` defined:
  - a counter increments each enabled cycle spent in WAITING;
  - when it reaches TIMEOUT_CYCLES without a ready, the valid drops, the state goes to DONE, `lsu_out`=0 for a read, and `lsu_error`=1;
  - `lsu_error` clears on the DONE→IDLE transition;
  - a ready sampled on the same edge as the limit is reached wins (normal completion, no error).
- Without `LSU_TIMEOUT_EN`:
  - the unit waits indefinitely;
  - `lsu_error` is tied to 0;
  - no counter exists.

## Structure
- `lsu_state_t` (2-bit enum: IDLE, REQUESTING, WAITING, DONE) goes into `states_pkg` next to `core_state_t`; the scheduler uses the same type.
- Sub-module `lsu_watchdog` (counter, limit compare, expire pulse) is instantiated only under `LSU_TIMEOUT_EN`.

## Test plan
- Read, zero-wait memory. Set `rs`=0x12 and drive `mem_read_ready`=1 with `mem_read_data`=0xA5 on the first valid cycle. Required: `mem_read_address`=0x12, DONE on edge 3, `lsu_out`=0xA5 held until UPDATE, then IDLE.
- Write with 4 wait cycles. Set `rs`=0x30, `rt`=0x7E. Required: `mem_write_valid` high for exactly 5 cycles with address 0x30 and data 0x7E; `lsu_out` unchanged.
- Both enables high with `rs`=0x05. Required: only `mem_read_valid` asserts; `mem_write_valid` stays 0 throughout.
- Assert `reset` low while in WAITING. Required: both valids, `lsu_state` and `lsu_out` read 0 before the next edge.
- Drop `enable` for 3 cycles while in WAITING. Required: state, valid and address are frozen; `mem_read_ready` pulses during those cycles are ignored; the access completes normally after re-enable.
- With `LSU_TIMEOUT_EN` defined and TIMEOUT_CYCLES=4, never assert ready. Required: valid drops after 4 WAITING cycles, DONE, `lsu_error`=1, `lsu_out`=0; `lsu_error` returns to 0 after UPDATE.
